// File: rtl/fir_post_decim_pkg.sv
// fir_post_decim shared types and helpers.
// Widths, clamp limits and the round/shift/saturate function.
package fir_post_decim_pkg;

  localparam int FIR_W = 32;
  localparam int OUT_W = 16;

  localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

  localparam logic signed [FIR_W:0] SAT_HI = 33'sd32767;
  localparam logic signed [FIR_W:0] SAT_LO = -33'sd32768;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } rq_t;

  // Rounding is done one bit wider than the input so it cannot wrap.
  function automatic rq_t requant(
    input logic signed [FIR_W-1:0] x,
    input int                      shift
  );
    logic signed [FIR_W:0] r;
    logic signed [FIR_W:0] one;
    rq_t o;
    one = '0;
    one[0] = 1'b1;
    r = {x[FIR_W-1], x};
    if (shift > 0) r = r + (one <<< (shift - 1));
    r = r >>> shift;
    o.sat  = 1'b0;
    o.data = r[OUT_W-1:0];
    if (r > SAT_HI) begin
      o.sat  = 1'b1;
      o.data = SAT_MAX;
    end else if (r < SAT_LO) begin
      o.sat  = 1'b1;
      o.data = SAT_MIN;
    end
    return o;
  endfunction

endpackage

// File: rtl/fir_post_decim_if.sv
// fir_post_decim stream bundle.
// Input samples from the FIR and the valid/ready output stream.
interface fir_post_decim_if;
  import fir_post_decim_pkg::*;

  logic                    in_valid;
  logic signed [FIR_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/fir_post_decim_sync_fifo.sv
// Small synchronous FIFO with occupancy output.
// Head reads as zero while empty.
module sync_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;

  // Pointer and occupancy next state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    if (push_i && !pop_i)      lvl_d = lvl_q + 1'b1;
    else if (!push_i && pop_i) lvl_d = lvl_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_q] <= data_i;
  end

  assign full_o  = lvl_q[AW];
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign data_o  = empty_o ? '0 : mem[rd_q];

endmodule

// File: rtl/fir_post_decim.sv
// FIR output stage: decimate, requantise to 16 bits, buffer.
// Overflow and drop events are kept in sticky flags.
module fir_post_decim
  import fir_post_decim_pkg::*;
#(
  parameter  int DECIM = 2,
  parameter  int SHIFT = 4,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  fir_post_decim_if.slave bus,
  input  logic            clr_flags,
  output logic [LW-1:0]   level,
  output logic            sat_flag,
  output logic            drop_flag,
  output logic [7:0]      drop_cnt
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DECIM - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          keep;
  rq_t           rq;

  logic                    q_valid_q, q_valid_d;
  logic signed [OUT_W-1:0] q_data_q, q_data_d;

  logic pop, push, drop, full, empty;

  logic       sat_q, sat_d;
  logic       drf_q, drf_d;
  logic [7:0] dcnt_q, dcnt_d;

  assign keep = bus.in_valid && (cnt_q == '0);
  assign rq   = requant(bus.in_data, SHIFT);

  assign q_valid_d = keep;
  assign q_data_d  = rq.data;

  assign bus.out_valid = ~empty;
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = q_valid_q & (~full | pop);
  assign drop = q_valid_q & ~push;

  // Phase counter only moves on accepted input samples.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid) cnt_d = (cnt_q == CMAX) ? '0 : cnt_q + 1'b1;
  end

  // Sticky flags and drop counter; a clear wins over a set.
  always_comb begin
    sat_d  = sat_q | (keep & rq.sat);
    drf_d  = drf_q | drop;
    dcnt_d = dcnt_q;
    if (drop && dcnt_q != 8'hFF) dcnt_d = dcnt_q + 1'b1;
    if (clr_flags) begin
      sat_d  = 1'b0;
      drf_d  = 1'b0;
      dcnt_d = '0;
    end
  end

  // Phase, stage-1 and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      q_valid_q <= 1'b0;
      q_data_q  <= '0;
      sat_q     <= 1'b0;
      drf_q     <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      q_valid_q <= q_valid_d;
      q_data_q  <= q_data_d;
      sat_q     <= sat_d;
      drf_q     <= drf_d;
      dcnt_q    <= dcnt_d;
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  (q_data_q),
    .pop_i   (pop),
    .data_o  (bus.out_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign sat_flag  = sat_q;
  assign drop_flag = drf_q;
  assign drop_cnt  = dcnt_q;

endmodule

// File: tb/tb_fir_post_decim.sv
// Bench for fir_post_decim: DECIM=1 and DECIM=2 instances
// driven in parallel, checked against a queue-based model.
module tb_fir_post_decim;
  import fir_post_decim_pkg::*;

  localparam int SH  = 4;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr_flags = 1'b0;

  logic [2:0] lv0, lv1;
  logic       sf0, sf1, df0, df1;
  logic [7:0] dc0, dc1;

  fir_post_decim_if b0 ();
  fir_post_decim_if b1 ();

  fir_post_decim #(.DECIM(1), .SHIFT(SH), .DEPTH(DEP)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .clr_flags(clr_flags),
    .level(lv0), .sat_flag(sf0), .drop_flag(df0), .drop_cnt(dc0)
  );

  fir_post_decim #(.DECIM(2), .SHIFT(SH), .DEPTH(DEP)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1), .clr_flags(clr_flags),
    .level(lv1), .sat_flag(sf1), .drop_flag(df1), .drop_cnt(dc1)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  int          dec_m [2];
  int unsigned cnt_m [2];
  bit          s1v_m [2];
  int          s1d_m [2];
  int          fq    [2][$];
  bit          sat_m [2];
  bit          drf_m [2];
  int          dc_m  [2];

  int got0 [$];
  int got1 [$];

  typedef struct {
    logic [31:0] din;
    int          exp;
    bit          sat;
  } vec_t;

  vec_t tv [10];

  function automatic void chk(string n, longint act, longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endfunction

  function automatic void ref_rq(input logic [31:0] d,
                                 output int r, output bit s);
    longint x;
    x = longint'($signed(d));
    if (SH > 0) x = x + (longint'(1) << (SH - 1));
    x = x >>> SH;
    s = 1'b0;
    if (x > 32767) begin
      x = 32767;
      s = 1'b1;
    end else if (x < -32768) begin
      x = -32768;
      s = 1'b1;
    end
    r = int'(x);
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 2; i++) begin
      cnt_m[i] = 0;
      s1v_m[i] = 1'b0;
      s1d_m[i] = 0;
      fq[i].delete();
      sat_m[i] = 1'b0;
      drf_m[i] = 1'b0;
      dc_m[i]  = 0;
    end
  endfunction

  function automatic void mdl(int i, bit v, logic [31:0] d,
                              bit rdy, bit clr);
    bit pop, keep, s, dropped;
    int r;
    pop  = (fq[i].size() > 0) && rdy;
    keep = v && (cnt_m[i] == 0);
    ref_rq(d, r, s);
    dropped = 1'b0;
    if (pop) void'(fq[i].pop_front());
    if (s1v_m[i]) begin
      if (fq[i].size() < DEP) fq[i].push_back(s1d_m[i]);
      else dropped = 1'b1;
    end
    if (clr) begin
      sat_m[i] = 1'b0;
      drf_m[i] = 1'b0;
      dc_m[i]  = 0;
    end else begin
      if (keep && s) sat_m[i] = 1'b1;
      if (dropped) begin
        drf_m[i] = 1'b1;
        if (dc_m[i] < 255) dc_m[i]++;
      end
    end
    s1v_m[i] = keep;
    s1d_m[i] = r;
    if (v) cnt_m[i] = (cnt_m[i] + 1) % dec_m[i];
  endfunction

  function automatic void chk_inst(int i, logic ov,
                                   logic signed [15:0] od,
                                   logic [2:0] lv, logic sf,
                                   logic df, logic [7:0] dc);
    string p;
    int hd;
    p  = (i == 0) ? "d1" : "d2";
    hd = (fq[i].size() > 0) ? fq[i][0] : 0;
    chk({p, ".out_valid"}, ov, fq[i].size() > 0);
    chk({p, ".out_data"}, od, hd);
    chk({p, ".level"}, lv, fq[i].size());
    chk({p, ".sat_flag"}, sf, sat_m[i]);
    chk({p, ".drop_flag"}, df, drf_m[i]);
    chk({p, ".drop_cnt"}, dc, dc_m[i]);
  endfunction

  function automatic void check_all();
    chk_inst(0, b0.out_valid, b0.out_data, lv0, sf0, df0, dc0);
    chk_inst(1, b1.out_valid, b1.out_data, lv1, sf1, df1, dc1);
  endfunction

  task automatic step(bit v, logic [31:0] d, bit rdy, bit clr);
    b0.in_valid  = v;
    b0.in_data   = d;
    b0.out_ready = rdy;
    b1.in_valid  = v;
    b1.in_data   = d;
    b1.out_ready = rdy;
    clr_flags    = clr;
    if (b0.out_valid && rdy) got0.push_back(int'(b0.out_data));
    if (b1.out_valid && rdy) got1.push_back(int'(b1.out_data));
    @(posedge clk);
    mdl(0, v, d, rdy, clr);
    mdl(1, v, d, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    mdl_reset();
    chk("rst.out_valid", b0.out_valid, 0);
    chk("rst.level", lv0, 0);
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    got0.delete();
    got1.delete();
  endtask

  task automatic cmp_list(string n, int act [$], int exp [$]);
    chk({n, ".count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk(n, act[i], exp[i]);
  endtask

  initial begin
    dec_m[0] = 1;
    dec_m[1] = 2;
    tv[0] = '{32'd100,        6,      1'b0};
    tv[1] = '{-32'sd100,      -6,     1'b0};
    tv[2] = '{32'd7,          0,      1'b0};
    tv[3] = '{32'd8,          1,      1'b0};
    tv[4] = '{-32'sd9,        -1,     1'b0};
    tv[5] = '{-32'sd8,        0,      1'b0};
    tv[6] = '{32'h7FFFFFFF,   32767,  1'b1};
    tv[7] = '{32'h80000000,   -32768, 1'b1};
    tv[8] = '{32'd524272,     32767,  1'b0};
    tv[9] = '{32'd524280,     32767,  1'b1};

    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_data", b0.out_data, 0);
    check_all();
    reset_n = 1'b1;

    // Requantisation table, two-cycle latency, sticky sat + clear.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tv[i].din, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("tv.valid", b0.out_valid, 1);
      chk("tv.data", b0.out_data, tv[i].exp);
      chk("tv.sat", sf0, tv[i].sat);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("tv.clr", sf0, 0);
    end

    // Decimation by 2 with an idle gap.
    do_reset();
    step(1'b1, 32'd16, 1'b1, 1'b0);
    step(1'b1, 32'd32, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'd48, 1'b1, 1'b0);
    step(1'b1, 32'd64, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    cmp_list("decim", got1, '{1, 3});

    // Back-to-back throughput at DECIM=1.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'(16 * (i + 1)), 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    cmp_list("thru", got0, '{1, 2, 3, 4, 5, 6, 7, 8});
    chk("thru.drop_cnt", dc0, 0);

    // Backpressure: 6 samples into a 4-deep FIFO.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'(16 * (i + 1)), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bp.level", lv0, 4);
    chk("bp.drop_flag", df0, 1);
    chk("bp.drop_cnt", dc0, 2);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    cmp_list("bp.drain", got0, '{1, 2, 3, 4});

    // Full FIFO with simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(16 * (i + 1)), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pp.full", lv0, 4);
    step(1'b1, 32'd80, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pp.level", lv0, 4);
    chk("pp.drop_flag", df0, 0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    cmp_list("pp.order", got0, '{1, 2, 3, 4, 5});

    // Reset mid-stream, then phase restarts at 0.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'(16 * (i + 1)), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mr.level", lv0, 3);
    do_reset();
    step(1'b1, 32'd160, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    cmp_list("mr.phase", got1, '{10});

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] d;
      bit v, r, c;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 2) == 0) d = $urandom;
      else d = 32'($signed($urandom_range(0, 1 << 21)) - (1 << 20));
      step(v, d, r, c);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fir_post_decim.md
# fir_post_decim

Output stage sitting directly downstream of the FIR filter. Accepts the filter's 32-bit signed output stream, decimates it by a fixed ratio, then rounds, shifts and saturates each kept sample to 16 bits. Results are buffered in a small FIFO and presented on a valid/ready interface to the next consumer. Overflow and drop events are reported through sticky flags and a saturating counter.

## Interface
- DECIM, default 2: decimation ratio, 1..16; DECIM=1 keeps every sample.
- SHIFT, default 4: right-shift applied after rounding, 0..16.
- DEPTH, default 4: FIFO depth, power of two, at least 2.
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data carries a FIR output this cycle.
- in_data  input  32 signed  FIR output sample.
- clr_flags  input  1  synchronous clear of sat_flag, drop_flag and drop_cnt.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  16 signed  FIFO head sample.
- level  output  clog2(DEPTH)+1  FIFO occupancy.
- sat_flag  output  1  sticky: a kept sample saturated.
- drop_flag  output  1  sticky: a kept sample was lost because the FIFO was full.
- drop_cnt  output  8  count of dropped samples, saturates at 255.

## Operation
- Phase counter cnt, range 0..DECIM-1, advances on every in_valid and wraps to 0. A sample is kept when cnt==0 at acceptance. cnt does not advance while in_valid=0.
- Requantisation of a kept sample:
  - Rounding: add 2^(SHIFT-1) when SHIFT>0, computed at 33 bits so it cannot wrap.
  - Shift: arithmetic right shift by SHIFT.
  - Saturation: clamp to [-32768, 32767]. Any clamp sets sat_flag.
- Stage 1 register (q_valid, q_data) holds the requantised sample. It is written every cycle, so q_valid=0 when nothing was kept.
- Stage 2: FIFO write when q_valid=1.
  - The write is permitted if the FIFO is not full, or if it is full and out_ready and out_valid are both 1 in the same cycle.
  - Otherwise the sample is discarded, drop_flag is set, and drop_cnt increments (saturating at 255).
- FIFO read occurs when out_valid and out_ready are both 1. Read and write in the same cycle leave level unchanged. Pointers wrap modulo DEPTH.
- out_data is the FIFO head and stays stable while out_valid=1 and out_ready=0.
- clr_flags has priority over a same-cycle set: flags and drop_cnt read 0 the next cycle.

## Timing
- Reset values: out_valid=0, out_data=0, level=0, sat_flag=0, drop_flag=0, drop_cnt=0. Internal state also resets: cnt=0, q_valid=0, both FIFO pointers 0.
- Latency: a kept sample accepted in cycle k appears on out_data with out_valid=1 in cycle k+2 if the FIFO was empty.
- Throughput: one kept sample per cycle when DECIM=1 and out_ready is held high, with no drops.
- Reset asserted mid-operation: all FIFO contents and any in-flight stage-1 sample are discarded immediately. The first sample after reset release is phase 0.
- Full FIFO plus a simultaneous pop and push: the push succeeds and level stays at DEPTH.

## Structure
- Shared package: FIR data width (32), output width (16), SAT_MAX/SAT_MIN constants, and a rounding/saturation function reused by other stages.
- One sub-module, sync_fifo: parameterised width and depth, with push/pop/full/empty/level. The decimator and requantiser stay in the top module.

## Test plan
- Rounding and shift (SHIFT=4, DECIM=1): in_data 100 then -100 -> out_data 6 then -6. sat_flag stays 0.
- Saturation: in_data 32'h7FFFFFFF then 32'h80000000 -> out_data 32767 then -32768, with sat_flag=1. A clr_flags pulse returns sat_flag to 0.
- Decimation (DECIM=2): inputs 16, 32, 48, 64, with an idle in_valid=0 cycle inserted between 32 and 48 -> outputs 1 and 3 only.
- Backpressure (DEPTH=4, DECIM=1, out_ready=0): 6 kept samples -> level=4, drop_flag=1, drop_cnt=2. Asserting out_ready then drains the first 4 samples in order.
- Full with simultaneous pop and push: at level=4, out_ready=1 while a new sample arrives -> no drop, level stays 4, and the order is preserved.
- Reset mid-stream: reset_n pulsed low while level=3 -> out_valid=0 and level=0 immediately. The next sample is kept as phase 0.
